fpu_arbiter: RTL and testbench

FPU_ARBITER -- requirements
Module: fpu_arbiter

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/fpu_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fpu_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg
//   Shared types and constants for the two-requester FPU arbiter.
//   - fpu_op_t    : 2-bit operation code, forwarded to the FPU uninterpreted
//   - fpu_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   - FPU_LAT_DEFAULT : default FPU latency in clock edges
//   - FPU_CNT_W   : width of the latency counter (covers latencies 1..15)
package fpu_pkg;

  typedef logic [1:0] fpu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } fpu_state_t;

  localparam int unsigned FPU_LAT_DEFAULT = 1;
  localparam int unsigned FPU_CNT_W       = 4;

  // One-hot requester mask from a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Two-input round-robin grant. When both requests are present the
//   requester that was NOT granted last wins; a lone request always wins.
//   Ports:
//     req        in  2  request bits, index 0/1
//     last_grant in  1  index of the most recently granted requester
//     grant      out 2  one-hot grant (all zero when nothing is requested)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter
//   Shares one pipelined FPU between two requesters. One operation is in
//   flight at a time: IDLE accepts a request, BUSY waits FPU_LAT edges for
//   the result, RESP holds the result until the owner consumes it.
//   Operands and op codes are passed through untouched.
//   Ports:
//     clk, rst_n            clock; asynchronous active-low reset
//     req_valid/req_ready   per-requester request handshake (2 bits)
//     req_a, req_b, req_op  per-requester operands and op code
//     rsp_valid/rsp_ready   per-requester response handshake (2 bits)
//     rsp_data              result for the requester whose rsp_valid is set
//     busy                  high whenever the FSM is not in IDLE
//     fpu_a, fpu_b, fpu_op  registered operands to the shared FPU
//     fpu_result            FPU result, valid FPU_LAT edges after operands
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned FPU_LAT = FPU_LAT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0][31:0] req_a,
  input  logic [1:0][31:0] req_b,
  input  fpu_op_t [1:0]   req_op,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [31:0]     rsp_data,
  output logic            busy,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output fpu_op_t         fpu_op,
  input  logic [31:0]     fpu_result
);

  // Reset is asserted asynchronously but released through two flops so
  // that every state flop leaves reset on the same, clean clock edge.
  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       rst_int_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_int_n  = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  fpu_state_t             state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [FPU_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]            fpu_a_q, fpu_a_d;
  logic [31:0]            fpu_b_q, fpu_b_d;
  fpu_op_t                fpu_op_q, fpu_op_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic [1:0]             rsp_valid_q, rsp_valid_d;
  // Keeps req_ready low on the first edge after internal reset release so
  // no handshake can be offered while flops are still coming out of reset.
  logic                   arb_en_q, arb_en_d;

  logic [1:0] grant;
  logic       accept;
  logic       gnt_idx;

  rr_arb2 u_rr_arb2 (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = arb_en_q && (state_q == ST_IDLE) && grant[gi];
  end

  // grant is a subset of req_valid, so any ready bit is a transfer.
  assign accept  = |req_ready;
  assign gnt_idx = grant[1];
  assign arb_en_d = 1'b1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    fpu_op_d     = fpu_op_q;
    rsp_data_d   = rsp_data_q;
    rsp_valid_d  = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          fpu_a_d      = req_a[gnt_idx];
          fpu_b_d      = req_b[gnt_idx];
          fpu_op_d     = req_op[gnt_idx];
          last_grant_d = gnt_idx;
          cnt_d        = FPU_CNT_W'(FPU_LAT);
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A count of 1 marks the edge on which fpu_result is valid; the
        // <= also recovers from a zero count instead of wrapping.
        if (cnt_q <= FPU_CNT_W'(1)) begin
          cnt_d       = '0;
          rsp_data_d  = fpu_result;
          rsp_valid_d = req_onehot(last_grant_q);
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - FPU_CNT_W'(1);
        end
      end
      ST_RESP: begin
        // Only the owner's rsp_ready can complete the response.
        if (rsp_ready[last_grant_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 2'b00;
      arb_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      fpu_op_q     <= fpu_op_d;
      rsp_data_q   <= rsp_data_d;
      rsp_valid_q  <= rsp_valid_d;
      arb_en_q     <= arb_en_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign fpu_a     = fpu_a_q;
  assign fpu_b     = fpu_b_q;
  assign fpu_op    = fpu_op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter
//   Drives fpu_arbiter (FPU_LAT=1) with directed and random traffic and
//   compares every cycle against a transaction-level model; a second
//   instance with FPU_LAT=3 is checked for latency and data.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a = '0;
  logic [1:0][31:0] req_b = '0;
  fpu_op_t [1:0]    req_op = '0;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready = '0;
  logic [31:0]      rsp_data;
  logic             busy;
  logic [31:0]      fpu_a, fpu_b, fpu_result;
  fpu_op_t          fpu_op;

  // latency-3 instance
  logic [1:0]       req_valid3 = '0;
  logic [1:0]       req_ready3;
  logic [1:0][31:0] req_a3 = '0;
  logic [1:0][31:0] req_b3 = '0;
  fpu_op_t [1:0]    req_op3 = '0;
  logic [1:0]       rsp_valid3;
  logic [1:0]       rsp_ready3 = '0;
  logic [31:0]      rsp_data3;
  logic             busy3;
  logic [31:0]      fpu_a3, fpu_b3, fpu_result3;
  fpu_op_t          fpu_op3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  // Stand-in for the shared FPU: any deterministic function of its
  // operands will do, except the one known single-precision sum.
  function automatic logic [31:0] fpu_func(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    if (a == 32'h4201_51EC && b == 32'h4242_147B && op == 2'b01) return 32'h42A1_B333;
    return (a ^ {b[15:0], b[31:16]}) + {op, 30'h0} + 32'h1;
  endfunction

  assign fpu_result = fpu_func(fpu_a, fpu_b, fpu_op);

  logic [31:0] pipe1_3, pipe2_3;
  always @(posedge clk) begin
    pipe1_3 <= fpu_func(fpu_a3, fpu_b3, fpu_op3);
    pipe2_3 <= pipe1_3;
  end
  assign fpu_result3 = pipe2_3;

  fpu_arbiter #(.FPU_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_result(fpu_result)
  );

  fpu_arbiter #(.FPU_LAT(LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
    .busy(busy3), .fpu_a(fpu_a3), .fpu_b(fpu_b3), .fpu_op(fpu_op3),
    .fpu_result(fpu_result3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // One operation at a time: it is in flight from the accept edge until
  // the owner takes the response; the response is visible from LAT edges
  // after acceptance onward.
  int          m_cyc, m_acc, m_owner, m_last;
  bit          m_active;
  logic [31:0] m_a, m_b, m_res, m_data;
  logic [1:0]  m_op;

  function automatic int model_pick(input logic [1:0] v, input int last);
    if (v == 2'b11) return (last == 0) ? 1 : 0;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_active = 0; m_last = 1; m_owner = 0; m_acc = 0; m_cyc = 0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_data = '0;
  endtask

  task automatic model_step();
    int g;
    if (!m_active) begin
      g = model_pick(req_valid, m_last);
      if (g >= 0) begin
        m_active = 1; m_owner = g; m_last = g;
        m_a = req_a[g]; m_b = req_b[g]; m_op = req_op[g];
        m_res = fpu_func(m_a, m_b, m_op);
        m_acc = m_cyc + 1;
      end
    end else if ((m_cyc - m_acc) >= LAT && rsp_ready[m_owner]) begin
      m_active = 0;
      n_done++;
      $display("[TB] txn req%0d a=%h b=%h op=%0d result=%h", m_owner, m_a, m_b, m_op, m_res);
    end
    m_cyc++;
    if (m_active && (m_cyc - m_acc) == LAT) m_data = m_res;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [1:0] exp_ready, exp_rv;
    int g;
    forever begin
      @(negedge clk);
      g = model_pick(req_valid, m_last);
      exp_ready = 2'b00;
      if (rst_n && !m_active && g >= 0) exp_ready = (g == 1) ? 2'b10 : 2'b01;
      exp_rv = 2'b00;
      if (m_active && (m_cyc - m_acc) >= LAT) exp_rv = (m_owner == 1) ? 2'b10 : 2'b01;
      check("req_ready", {30'b0, req_ready}, {30'b0, exp_ready});
      check("rsp_valid", {30'b0, rsp_valid}, {30'b0, exp_rv});
      check("rsp_data", rsp_data, m_data);
      check("busy", {31'b0, busy}, {31'b0, m_active});
      check("fpu_a", fpu_a, m_a);
      check("fpu_b", fpu_b, m_b);
      check("fpu_op", {30'b0, fpu_op}, {30'b0, m_op});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; req_valid3 = '0; rsp_ready3 = '0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    int lat, ngr, seen;
    int gseq[4];
    int gcyc[4];
    int cyc;
    logic [31:0] specials[4];
    specials[0] = 32'h7FC0_0000; // quiet NaN
    specials[1] = 32'h7F80_0000; // +Inf
    specials[2] = 32'h0000_0001; // smallest denormal
    specials[3] = 32'hFF80_0000; // -Inf

    // reset values, with requests asserted while reset is held
    req_valid = 2'b11;
    repeat (3) step();
    check("rst_req_ready", {30'b0, req_ready}, 32'h0);
    check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_busy3", {31'b0, busy3}, 32'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    repeat (5) step();

    // reference vector on requester 0
    req_a[0] = 32'h4201_51EC; req_b[0] = 32'h4242_147B; req_op[0] = 2'b01;
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    check("ready0_alone", {30'b0, req_ready}, 32'h1);
    step();
    req_valid = 2'b00;
    check("fpu_a_vec", fpu_a, 32'h4201_51EC);
    lat = 0;
    while (lat < 20) begin
      step(); lat++;
      if (rsp_valid != 2'b00) break;
    end
    check("lat1_edges", lat, 32'd1);
    check("vec_rsp_valid", {30'b0, rsp_valid}, 32'h1);
    check("vec_rsp_data", rsp_data, 32'h42A1_B333);

    // non-owner rsp_ready must not complete
    rsp_ready = 2'b10;
    repeat (3) begin
      step();
      check("nonowner_hold", {30'b0, rsp_valid}, 32'h1);
    end

    // stall in RESP with both requesters asking
    rsp_ready = 2'b00; req_valid = 2'b11; req_a[1] = 32'h1234_5678;
    repeat (5) begin
      step();
      check("stall_rsp_valid", {30'b0, rsp_valid}, 32'h1);
      check("stall_rsp_data", rsp_data, 32'h42A1_B333);
      check("stall_req_ready", {30'b0, req_ready}, 32'h0);
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    step();
    check("done_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("done_busy", {31'b0, busy}, 32'h0);
    rsp_ready = 2'b00;

    // round-robin from reset with both requesters held, rsp_ready high
    do_reset();
    req_a[0] = 32'hAAAA_0000; req_b[0] = 32'h0000_1111; req_op[0] = 2'b10;
    req_a[1] = 32'hBBBB_0000; req_b[1] = 32'h0000_2222; req_op[1] = 2'b11;
    req_valid = 2'b11; rsp_ready = 2'b11;
    ngr = 0; cyc = 0;
    while (ngr < 4 && cyc < 60) begin
      step(); cyc++;
      if (rsp_valid != 2'b00) begin
        gseq[ngr] = rsp_valid[1] ? 1 : 0;
        gcyc[ngr] = cyc;
        ngr++;
      end
    end
    req_valid = 2'b00;
    check("rr_count", ngr, 32'd4);
    for (int k = 0; k < ngr; k++) begin
      check("rr_grant", gseq[k], (k % 2 == 0) ? 32'd0 : 32'd1);
      if (k > 0) check("rr_period", gcyc[k] - gcyc[k-1], LAT + 2);
    end

    // reset in the middle of an operation
    repeat (3) step();
    req_a[0] = 32'h0BAD_F00D; req_valid = 2'b01; rsp_ready = 2'b00;
    step();
    req_valid = 2'b00;
    check("pre_rst_busy", {31'b0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'h0);
    check("midrst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
    check("midrst_fpu_a", fpu_a, 32'h0);
    check("midrst_fpu_op", {30'b0, fpu_op}, 32'h0);
    check("midrst_rsp_data", rsp_data, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      step();
      if (rsp_valid != 2'b00) seen = 1;
    end
    check("no_rsp_after_rst", seen, 32'd0);

    // latency-3 instance with the reference vector
    req_a3[0] = 32'h4201_51EC; req_b3[0] = 32'h4242_147B; req_op3[0] = 2'b01;
    req_valid3 = 2'b01; rsp_ready3 = 2'b00;
    step();
    req_valid3 = 2'b00;
    lat = 0;
    while (lat < 20) begin
      step(); lat++;
      if (rsp_valid3 != 2'b00) break;
    end
    check("lat3_edges", lat, 32'd3);
    check("lat3_rsp_data", rsp_data3, 32'h42A1_B333);
    rsp_ready3 = 2'b01;
    step();
    check("lat3_done", {30'b0, rsp_valid3}, 32'h0);
    rsp_ready3 = 2'b00;

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) do_reset();
      req_valid = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_a[i]  = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
        req_b[i]  = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
        req_op[i] = 2'($urandom_range(0, 3));
      end
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step();
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (10) step();
    check("random_progress", {31'b0, (n_done > 50)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
